// File: rtl/led_zone_serializer.sv
// led_zone_serializer
//   Pops one DATA_W-bit zone word per zone from the zone-mean FIFO and shifts it MSB-first to
//   the LED driver chain. After ZONES words it pulses led_latch so the chain applies the frame.
//   Runs entirely in the FIFO read-clock domain.
//
// Ports
//   rd_clk      FIFO read clock (sole clock)
//   rst         asynchronous, active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid RD_LAT cycles after rd_start
//   rd_start    one-cycle read request to the FIFO
//   led_sclk    serial clock, CLK_DIV cycles low then CLK_DIV cycles high per bit
//   led_sdo     serial data, only changes while led_sclk is low
//   led_latch   frame latch pulse, LATCH_CYC cycles wide
//   busy        high in every state except idle
//   stall       high while waiting mid-frame on an empty FIFO
//   frame_done  one-cycle pulse in the idle cycle that follows the latch
module led_zone_serializer #(
  parameter int unsigned ZONES     = 40,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned LATCH_CYC = 8
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              rd_start,
  output logic              led_sclk,
  output logic              led_sdo,
  output logic              led_latch,
  output logic              busy,
  output logic              stall,
  output logic              frame_done
);

  localparam int unsigned ZoneW  = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int unsigned BitW   = $clog2(DATA_W + 1);
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CycMax = (RD_LAT > LATCH_CYC) ? RD_LAT : LATCH_CYC;
  localparam int unsigned CycW   = $clog2(CycMax + 1);

  localparam logic [ZoneW-1:0] ZoneLast = ZoneW'(ZONES - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [CycW-1:0]  RdLast   = CycW'(RD_LAT - 1);
  localparam logic [CycW-1:0]  LatLast  = CycW'(LATCH_CYC - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWaitData, StShift, StLatch} state_e;

  state_e             state_q, state_d;
  logic [ZoneW-1:0]   zone_cnt_q, zone_cnt_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0]    div_q, div_d;
  // Shared by the read-latency wait and the latch width; the two never overlap.
  logic [CycW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [DATA_W-1:0]  sr_q, sr_d;

  logic rd_start_q, rd_start_d;
  logic sclk_q, sclk_d;
  logic sdo_q, sdo_d;
  logic latch_q, latch_d;
  logic busy_q, busy_d;
  logic stall_q, stall_d;
  logic done_q, done_d;

  always_comb begin
    state_d    = state_q;
    zone_cnt_d = zone_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    cyc_cnt_d  = cyc_cnt_q;
    sr_d       = sr_q;
    sclk_d     = 1'b0;
    sdo_d      = sdo_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        zone_cnt_d = '0;
        // The frame_done cycle always idles, leaving a gap before the next frame's read.
        if (!fifo_empty && !done_q) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // rd_start_q is high in the cycle the request goes out.
        if (rd_start_q) begin
          state_d   = StWaitData;
          cyc_cnt_d = '0;
        end
      end
      StWaitData: begin
        if (cyc_cnt_q == RdLast) begin
          sr_d      = fifo_dout;
          sdo_d     = fifo_dout[DATA_W-1];
          bit_cnt_d = '0;
          div_d     = '0;
          cyc_cnt_d = '0;
          state_d   = StShift;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      StShift: begin
        sclk_d = sclk_q;
        div_d  = div_q + 1'b1;
        if (div_q == DivLast) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          // End of the high half: the bit is done.
          if (sclk_q) begin
            if (bit_cnt_q == BitLast) begin
              if (zone_cnt_q == ZoneLast) begin
                state_d   = StLatch;
                cyc_cnt_d = '0;
              end else begin
                zone_cnt_d = zone_cnt_q + 1'b1;
                state_d    = StReq;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              sr_d      = {sr_q[DATA_W-2:0], 1'b0};
              sdo_d     = sr_d[DATA_W-1];
            end
          end
        end
      end
      StLatch: begin
        if (cyc_cnt_q == LatLast) begin
          state_d    = StIdle;
          zone_cnt_d = '0;
          cyc_cnt_d  = '0;
          done_d     = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StLatch) begin
      sdo_d = 1'b0;
    end

    // Outputs are registered from next-state values so they line up with state_q.
    rd_start_d = (state_d == StReq) && !fifo_empty;
    latch_d    = (state_d == StLatch);
    busy_d     = (state_d != StIdle);
    stall_d    = (state_d == StReq) && !rd_start_d && (zone_cnt_d != '0);
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      zone_cnt_q <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
      cyc_cnt_q  <= '0;
      sr_q       <= '0;
      rd_start_q <= 1'b0;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      zone_cnt_q <= zone_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      cyc_cnt_q  <= cyc_cnt_d;
      sr_q       <= sr_d;
      rd_start_q <= rd_start_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      latch_q    <= latch_d;
      busy_q     <= busy_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
    end
  end

  assign rd_start   = rd_start_q;
  assign led_sclk   = sclk_q;
  assign led_sdo    = sdo_q;
  assign led_latch  = latch_q;
  assign busy       = busy_q;
  assign stall      = stall_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_led_zone_serializer.sv
// Bench for led_zone_serializer: behavioural FIFO (rd_start -> rd_en register -> read),
// a negedge monitor that records the serial stream, and directed frame-level tests.
module tb_led_zone_serializer;

  localparam int DW = 24;

  logic          rd_clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          rd_start, led_sclk, led_sdo, led_latch, busy, stall, frame_done;

  led_zone_serializer dut (
    .rd_clk     (rd_clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .rd_start   (rd_start),
    .led_sclk   (led_sclk),
    .led_sdo    (led_sdo),
    .led_latch  (led_latch),
    .busy       (busy),
    .stall      (stall),
    .frame_done (frame_done)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model
  logic [DW-1:0] mem [0:511];
  int   wptr = 0;
  int   rptr = 0;
  logic rd_en_q = 1'b0;

  assign fifo_empty = (wptr == rptr);

  always @(posedge rd_clk) begin
    rd_en_q <= rd_start;
    if (rd_en_q) begin
      fifo_dout <= mem[rptr];
      rptr      <= rptr + 1;
    end
  end

  // Monitor
  int   cyc = 0, rd_cnt = 0, rise_cnt = 0, sdo_viol = 0, rd_bad = 0;
  int   latch_hi = 0, latch_pulses = 0, stall_cyc = 0, stall_bad = 0;
  logic prev_sclk = 1'b0, prev_sdo = 1'b0, prev_latch = 1'b0;
  logic bits [$];
  int   fd_cyc [$];
  int   rd_cyc [$];

  always @(negedge rd_clk) begin
    cyc        <= cyc + 1;
    prev_sclk  <= led_sclk;
    prev_sdo   <= led_sdo;
    prev_latch <= led_latch;
    if (rd_start) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc.push_back(cyc);
      if (fifo_empty) rd_bad <= rd_bad + 1;
    end
    if (led_sclk && !prev_sclk) begin
      rise_cnt <= rise_cnt + 1;
      bits.push_back(led_sdo);
    end
    if (led_sclk && prev_sclk && (led_sdo != prev_sdo)) sdo_viol <= sdo_viol + 1;
    if (led_latch) latch_hi <= latch_hi + 1;
    if (led_latch && !prev_latch) latch_pulses <= latch_pulses + 1;
    if (frame_done) fd_cyc.push_back(cyc);
    if (stall) begin
      stall_cyc <= stall_cyc + 1;
      if (led_sclk || rd_start) stall_bad <= stall_bad + 1;
    end
  end

  // Checking helpers
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wptr] = w;
    wptr = wptr + 1;
  endtask

  function automatic logic [DW-1:0] get_word(input int b);
    logic [DW-1:0] w = 'x;
    for (int j = 0; j < DW; j++) begin
      if (b + j < bits.size()) w[DW-1-j] = bits[b+j];
    end
    return w;
  endfunction

  function automatic int fd_at(input int i);
    return (i < fd_cyc.size()) ? fd_cyc[i] : -1;
  endfunction

  function automatic int rd_at(input int i);
    return (i < rd_cyc.size()) ? rd_cyc[i] : -1;
  endfunction

  task automatic check_stream(input string name, input int b_start, input int w_start,
                              input int n_words);
    int bad = 0;
    for (int k = 0; k < n_words; k++) begin
      for (int j = 0; j < DW; j++) begin
        int idx = b_start + k * DW + j;
        if (idx >= bits.size()) bad++;
        else if (bits[idx] !== mem[w_start+k][DW-1-j]) bad++;
      end
    end
    check(name, bad, 0);
  endtask

  task automatic wait_fd(input int target, input int budget, input string name);
    int i = 0;
    while (fd_cyc.size() < target && i < budget) begin
      @(negedge rd_clk);
      i++;
    end
    check(name, fd_cyc.size(), target);
  endtask

  task automatic wait_rd(input int target, input int budget, input string name);
    int i = 0;
    while (rd_cnt < target && i < budget) begin
      @(negedge rd_clk);
      i++;
    end
    check(name, rd_cnt, target);
  endtask

  task automatic wait_stall(input int budget, input string name);
    int i = 0;
    while (stall !== 1'b1 && i < budget) begin
      @(negedge rd_clk);
      i++;
    end
    check(name, stall, 1);
  endtask

  function automatic logic [6:0] outs();
    return {rd_start, led_sclk, led_sdo, led_latch, busy, stall, frame_done};
  endfunction

  typedef struct {
    logic [DW-1:0] word;
    logic          first_bit;
    logic          last_bit;
    int            ones;
  } vec_t;

  vec_t vecs [8];

  int s_rd, s_rise, s_b, s_w, s_fd, s_lp, s_lh, s_sc, s_sb, s_rdi;
  logic s_sdo;

  task automatic snap();
    s_rd   = rd_cnt;
    s_rise = rise_cnt;
    s_b    = bits.size();
    s_w    = wptr;
    s_fd   = fd_cyc.size();
    s_lp   = latch_pulses;
    s_lh   = latch_hi;
    s_sc   = stall_cyc;
    s_sb   = stall_bad;
    s_rdi  = rd_cyc.size();
  endtask

  initial begin
    logic [DW-1:0] got;
    int t0;

    vecs[0] = '{24'h800001, 1'b1, 1'b1, 2};
    vecs[1] = '{24'hFFFFFF, 1'b1, 1'b1, 24};
    vecs[2] = '{24'h000000, 1'b0, 1'b0, 0};
    vecs[3] = '{24'hA5A5A5, 1'b1, 1'b1, 12};
    vecs[4] = '{24'h123456, 1'b0, 1'b0, 9};
    vecs[5] = '{24'h7FFFFE, 1'b0, 1'b0, 22};
    vecs[6] = '{24'h000001, 1'b0, 1'b1, 1};
    vecs[7] = '{24'hC00003, 1'b1, 1'b1, 4};

    // Reset: asserted between clock edges, outputs clear immediately
    #7 rst = 1'b1;
    #1;
    check("reset outputs", 32'(outs()), 0);
    repeat (3) @(negedge rd_clk);
    rst = 1'b0;
    snap();
    repeat (10) @(negedge rd_clk);
    check("idle no rd_start", rd_cnt - s_rd, 0);
    check("idle outputs", 32'(outs()), 0);
    check("idle zone_cnt", 32'(dut.zone_cnt_q), 0);

    // Single frame of 0x000000..0x000027
    snap();
    for (int i = 0; i < 40; i++) push(24'(i));
    wait_fd(s_fd + 1, 9000, "frame1 done");
    repeat (4) @(negedge rd_clk);
    check("frame1 rd_start count", rd_cnt - s_rd, 40);
    check("frame1 sclk rises", rise_cnt - s_rise, 960);
    check_stream("frame1 bitstream", s_b, s_w, 40);
    check("frame1 latch width", latch_hi - s_lh, 8);
    check("frame1 latch pulses", latch_pulses - s_lp, 1);
    t0 = rd_at(s_rdi);
    check("frame1 done timing", fd_at(s_fd) - (t0 - 1), 7809);
    check("frame1 no stall", stall_cyc - s_sc, 0);
    check("frame1 idle after", 32'(outs()), 0);

    // Table frame: hand-computed words first, then filler
    snap();
    for (int i = 0; i < 8; i++) push(vecs[i].word);
    for (int i = 8; i < 40; i++) push(24'(32'h5A0000 ^ (i * 32'h010203)));
    wait_fd(s_fd + 1, 9000, "table frame done");
    repeat (4) @(negedge rd_clk);
    for (int i = 0; i < 8; i++) begin
      got = get_word(s_b + i * DW);
      check($sformatf("vec%0d word", i), 32'(got), 32'(vecs[i].word));
      check($sformatf("vec%0d first bit", i), 32'(got[DW-1]), 32'(vecs[i].first_bit));
      check($sformatf("vec%0d last bit", i), 32'(got[0]), 32'(vecs[i].last_bit));
      check($sformatf("vec%0d ones", i), $countones(got), vecs[i].ones);
    end
    check_stream("table filler bitstream", s_b + 8 * DW, s_w + 8, 32);
    check("table rd_start count", rd_cnt - s_rd, 40);

    // Underrun: 10 words, stall, then 30 more
    snap();
    for (int i = 0; i < 10; i++) push(24'(32'hA00000 + i * 32'h111));
    t0 = s_w;
    wait_stall(2500, "underrun stall seen");
    check("underrun zone_cnt", 32'(dut.zone_cnt_q), 10);
    check("underrun rd before stall", rd_cnt - s_rd, 10);
    s_rd   = rd_cnt;
    s_rise = rise_cnt;
    s_sdo  = led_sdo;
    repeat (500) @(negedge rd_clk);
    check("underrun stall held", stall, 1);
    check("underrun sclk low", led_sclk, 0);
    check("underrun sdo held", led_sdo, s_sdo);
    check("underrun no rd_start", rd_cnt - s_rd, 0);
    check("underrun no sclk", rise_cnt - s_rise, 0);
    for (int i = 10; i < 40; i++) push(24'(32'hA00000 + i * 32'h111));
    wait_fd(s_fd + 1, 9000, "underrun frame done");
    repeat (4) @(negedge rd_clk);
    check_stream("underrun bitstream", s_b, t0, 40);
    check("underrun stall cleared", stall, 0);
    check("underrun stall clean", stall_bad - s_sb, 0);

    // Reset during zone 5 shift
    snap();
    for (int i = 0; i < 40; i++) push(24'(32'h100000 + i * 32'h1021));
    t0 = s_w;
    wait_rd(s_rd + 6, 1500, "midreset reach zone5");
    repeat (60) @(negedge rd_clk);
    check("midreset busy before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midreset outputs", 32'(outs()), 0);
    check("midreset zone_cnt", 32'(dut.zone_cnt_q), 0);
    repeat (3) @(negedge rd_clk);
    check("midreset no latch", latch_pulses - s_lp, 0);
    for (int i = 40; i < 46; i++) push(24'(32'h100000 + i * 32'h1021));
    s_b  = bits.size();
    s_rd = rd_cnt;
    s_lp = latch_pulses;
    rst = 1'b0;
    wait_fd(s_fd + 1, 9000, "midreset next frame done");
    repeat (4) @(negedge rd_clk);
    check_stream("midreset next bitstream", s_b, t0 + 6, 40);
    check("midreset next rd count", rd_cnt - s_rd, 40);
    check("midreset one latch", latch_pulses - s_lp, 1);
    check("midreset fifo drained", 32'(rptr), 32'(wptr));

    // Back-to-back frames
    snap();
    for (int i = 0; i < 80; i++) push(24'(32'hF00000 - i * 32'h3E7));
    wait_fd(s_fd + 2, 17000, "b2b frames done");
    repeat (4) @(negedge rd_clk);
    check("b2b done spacing", fd_at(s_fd + 1) - fd_at(s_fd), 7810);
    check("b2b rd_start count", rd_cnt - s_rd, 80);
    check_stream("b2b bitstream", s_b, s_w, 80);
    check("b2b latch pulses", latch_pulses - s_lp, 2);
    check("b2b latch width", latch_hi - s_lh, 16);

    check("rd_start while empty", rd_bad, 0);
    check("sdo change while sclk high", sdo_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_zone_serializer.md
# led_zone_serializer

Downstream consumer of the zone-mean FIFO (`fifo_led`) in the local-dimming backlight path; runs entirely in the FIFO read-clock domain. Pops one 24-bit zone value per zone through the FIFO's `rd_start`/`empty`/`dout` interface and shifts it MSB-first to the LED driver chain over a serial clock/data pair. After every `ZONES` words it pulses a latch so the driver chain applies the new frame.

## Interface
- `ZONES`, 40, zone words per frame (matches the 40 words written per line group upstream)
- `DATA_W`, 24, bits per zone word
- `RD_LAT`, 2, cycles from `rd_start` high to valid `fifo_dout` (1 for the `rd_en` register, 1 for the FIFO read)
- `CLK_DIV`, 4, `rd_clk` cycles per `led_sclk` half-period
- `LATCH_CYC`, 8, `led_latch` high width in cycles

- `rd_clk`  in  1  sole clock, the FIFO read clock
- `rst`  in  1  asynchronous, active-high reset
- `fifo_empty`  in  1  FIFO `empty`
- `fifo_dout`  in  DATA_W  FIFO read data
- `rd_start`  out  1  one-cycle read request to the FIFO port
- `led_sclk`  out  1  serial clock to the LED driver
- `led_sdo`  out  1  serial data; changes only while `led_sclk` is low
- `led_latch`  out  1  frame latch pulse
- `busy`  out  1  high in every state except IDLE
- `stall`  out  1  high while waiting mid-frame on an empty FIFO
- `frame_done`  out  1  one-cycle pulse after the latch completes

## Operation
- All outputs are registered. During and after reset all outputs are 0, FSM is IDLE, and all counters are 0.
- FSM states: IDLE, REQ, WAIT_DATA, SHIFT, LATCH.
- IDLE:
  - `zone_cnt` is 0.
  - When `fifo_empty`=0, go to REQ.
- REQ:
  - If `fifo_empty`=0: assert `rd_start` for exactly one cycle, then go to WAIT_DATA.
  - If `fifo_empty`=1: stay in REQ. `stall`=1 when `zone_cnt`≠0. `led_sclk` stays 0 and `led_sdo` holds its value.
- WAIT_DATA:
  - Lasts RD_LAT cycles.
  - At the last edge, capture `fifo_dout` into the shift register and clear `bit_cnt` and the divider, then go to SHIFT.
- SHIFT:
  - Each bit takes 2·CLK_DIV cycles: `led_sclk`=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - `led_sdo` = shift-register MSB. The register shifts left on the cycle `led_sclk` returns to 0.
  - After DATA_W bits: if `zone_cnt`=ZONES-1, go to LATCH; otherwise increment `zone_cnt` and go to REQ.
- LATCH:
  - `led_latch`=1 for LATCH_CYC cycles, with `led_sclk`=0 and `led_sdo`=0.
  - Then `frame_done`=1 for one cycle, coinciding with the return to IDLE.
  - `zone_cnt` resets to 0.
- Widths: `zone_cnt` is $clog2(ZONES), `bit_cnt` is $clog2(DATA_W+1), the divider is $clog2(CLK_DIV). No wrap occurs beyond ZONES-1.
- `rd_start` is never asserted while `fifo_empty`=1, nor outside REQ. At most one read is outstanding.
- Reset mid-frame: return to IDLE immediately. The partial frame is discarded with no latch, and the FIFO is not drained.

## Timing
- Per zone with the FIFO non-empty: 1 (REQ) + RD_LAT + DATA_W·2·CLK_DIV cycles. With defaults: 1 + 2 + 192 = 195.
- Full frame with defaults:
  - IDLE exit, then 40·195 = 7800 cycles of zones.
  - LATCH for 8 cycles.
  - `frame_done` in the cycle after that, i.e. 7809 cycles after leaving IDLE.
- `led_sdo` is stable CLK_DIV cycles before each `led_sclk` rising edge and CLK_DIV cycles after it.
- First `rd_start` is in the cycle after IDLE sees `fifo_empty`=0.
- Back-to-back frames: at least one IDLE cycle between `frame_done` and the next `rd_start`.
- `busy` rises the cycle after IDLE exit and falls together with the `frame_done` cycle.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately; no `rd_start` for the next 10 cycles with `fifo_empty`=1.
- **Single frame:** preload 40 words 0x000000..0x000027 → exactly 40 `rd_start` pulses and 960 `led_sclk` rising edges. Bits sampled on the rising edges equal the words MSB first. `led_latch` is high for 8 cycles, and `frame_done` arrives 7809 cycles after the first `rd_start`−1.
- **Bit order:** a single zone word 0x800001 → first sampled bit is 1, the next 22 bits are 0, the last bit is 1.
- **Underrun:** the FIFO holds 10 words, then 30 more are written 500 cycles later → after zone 9 completes, `stall`=1, `led_sclk`=0, no `rd_start`. Streaming resumes on refill, and the total bitstream equals the 40 words in order.
- **Reset mid-frame:** assert `rst` during zone 5 SHIFT → `led_latch` never pulses, `zone_cnt` is 0. The next frame starts cleanly from the remaining FIFO words.
- **Back-to-back:** preload 80 words → two `frame_done` pulses 7810 cycles apart (one IDLE cycle), and 80 `rd_start` pulses total.
